// File: rtl/ms_slot_arbiter.sv
// Round-robin time-slot arbiter: four requesters share one resource, each tenure
// bounded to SLOT_MS ticks of ce1ms and followed by GUARD_MS ticks of dead time.
module ms_slot_arbiter #(
    parameter int unsigned SLOT_MS  = 10,
    parameter int unsigned GUARD_MS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce1ms,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       slot_end
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ID_W  = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GUARD = 2'd2;

    localparam logic [CNT_W-1:0] SLOT_LOAD  = CNT_W'(SLOT_MS);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_MS);
    localparam logic             HAS_GUARD  = (GUARD_MS != 0);

    logic [1:0]       state,     state_d;
    logic [CNT_W-1:0] slot_cnt,  slot_cnt_d;
    logic [CNT_W-1:0] guard_cnt, guard_cnt_d;
    logic [ID_W-1:0]  last_id,   last_id_d;
    logic [N_REQ-1:0] gnt_d;
    logic [ID_W-1:0]  gnt_id_d;
    logic             busy_d;
    logic             slot_end_d;

    logic             win_vld;
    logic [ID_W-1:0]  win_id;
    logic             timeout;
    logic             release_req;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slot_cnt  <= '0;
            guard_cnt <= '0;
            last_id   <= 2'd3;
            gnt       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            slot_end  <= 1'b0;
        end else begin
            state     <= state_d;
            slot_cnt  <= slot_cnt_d;
            guard_cnt <= guard_cnt_d;
            last_id   <= last_id_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            busy      <= busy_d;
            slot_end  <= slot_end_d;
        end
    end

    // Next-state and next-output logic; search starts one past the last winner
    always_comb begin
        state_d     = state;
        slot_cnt_d  = slot_cnt;
        guard_cnt_d = guard_cnt;
        last_id_d   = last_id;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        slot_end_d  = 1'b0;
        win_vld     = 1'b0;
        win_id      = last_id;

        for (int i = 1; i <= int'(N_REQ); i++) begin
            if (!win_vld && req[ID_W'(last_id + ID_W'(i))]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(last_id + ID_W'(i));
            end
        end

        timeout     = ce1ms && (slot_cnt == CNT_W'(1));
        release_req = !req[gnt_id];

        case (state)
            IDLE: begin
                gnt_d = '0;
                if (win_vld) begin
                    state_d    = GRANT;
                    gnt_d      = N_REQ'(1) << win_id;
                    gnt_id_d   = win_id;
                    last_id_d  = win_id;
                    slot_cnt_d = SLOT_LOAD;
                end
            end
            GRANT: begin
                if (timeout || release_req) begin
                    gnt_d      = '0;
                    slot_end_d = timeout;
                    if (HAS_GUARD) begin
                        state_d     = GUARD;
                        guard_cnt_d = GUARD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ce1ms) begin
                    slot_cnt_d = slot_cnt - CNT_W'(1);
                end
            end
            GUARD: begin
                gnt_d = '0;
                if (ce1ms) begin
                    if (guard_cnt == CNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        guard_cnt_d = guard_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_ms_slot_arbiter.sv
// Directed bench for ms_slot_arbiter: SLOT_MS=3, ce1ms every 10 clk, one instance
// with GUARD_MS=1 and one with GUARD_MS=0.
`timescale 1ns/1ps
module tb_ms_slot_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce1ms;
    logic [3:0] req;
    logic [3:0] req0;
    logic [3:0] gnt, gnt0;
    logic [1:0] gnt_id, gnt_id0;
    logic       busy, busy0;
    logic       slot_end, slot_end0;

    int n_cmp  = 0;
    int n_fail = 0;
    int tick_cnt = 0;

    typedef struct {
        logic [3:0] req;
        logic       hold;
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
    } vec_t;

    vec_t tbl[11];

    ms_slot_arbiter #(.SLOT_MS(3), .GUARD_MS(1)) u_dut (
        .clk(clk), .rst(rst), .ce1ms(ce1ms), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .slot_end(slot_end)
    );

    ms_slot_arbiter #(.SLOT_MS(3), .GUARD_MS(0)) u_dut0 (
        .clk(clk), .rst(rst), .ce1ms(ce1ms), .req(req0),
        .gnt(gnt0), .gnt_id(gnt_id0), .busy(busy0), .slot_end(slot_end0)
    );

    always #5 clk = ~clk;

    // ce1ms: one-cycle pulse every 10 clk, changed shortly after the rising edge
    initial begin
        ce1ms = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ce1ms = (tick_cnt == 9);
            tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    initial begin
        int zc;
        int hc;
        int bc;
        int nce;
        int k;
        logic prev_hold;
        logic [3:0] exp0;

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
        tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 2'd1};
        tbl[7]  = '{4'b0010, 1'b1, 4'b0010, 2'd1};
        tbl[8]  = '{4'b1010, 1'b1, 4'b1000, 2'd3};
        tbl[9]  = '{4'b1010, 1'b1, 4'b0010, 2'd1};
        tbl[10] = '{4'b0011, 1'b1, 4'b0001, 2'd0};

        // Reset with all requesters active
        rst  = 1'b1;
        req  = 4'b1111;
        req0 = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_slot_end", 32'(slot_end), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table: grant order, slot length, guard gap, early release
        prev_hold = 1'b0;
        for (int i = 0; i < 11; i++) begin
            req = tbl[i].req;
            zc = 1;
            while (gnt == 4'b0 && zc < 60) begin
                zc++;
                @(negedge clk);
            end
            if (i > 0 && prev_hold) chk_range($sformatf("gap[%0d]", i), zc, 2, 11);
            chk($sformatf("gnt[%0d]", i), 32'(gnt), 32'(tbl[i].exp_gnt));
            chk($sformatf("gnt_id[%0d]", i), 32'(gnt_id), 32'(tbl[i].exp_id));
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'h1);
            if (tbl[i].hold) begin
                hc = 0;
                while (gnt != 4'b0 && hc < 60) begin
                    hc++;
                    @(negedge clk);
                end
                chk_range($sformatf("slot_len[%0d]", i), hc, 21, 30);
                chk($sformatf("slot_end_hi[%0d]", i), 32'(slot_end), 32'h1);
                @(negedge clk);
                chk($sformatf("slot_end_lo[%0d]", i), 32'(slot_end), 32'h0);
                chk($sformatf("guard_gnt[%0d]", i), 32'(gnt), 32'h0);
            end else begin
                repeat (4) @(negedge clk);
                req = 4'b0000;
                @(negedge clk);
                chk($sformatf("rel_gnt[%0d]", i), 32'(gnt), 32'h0);
                chk($sformatf("rel_slot_end[%0d]", i), 32'(slot_end), 32'h0);
                bc = 0;
                while (busy && bc < 20) begin
                    bc++;
                    if (slot_end) chk($sformatf("rel_no_pulse[%0d]", i), 32'(slot_end), 32'h0);
                    @(negedge clk);
                end
                chk_range($sformatf("busy_fall[%0d]", i), bc, 1, 11);
            end
            prev_hold = tbl[i].hold;
        end

        // Release on the same cycle as the final tick: timeout wins
        req = 4'b0010;
        k = 0;
        while (gnt == 4'b0 && k < 60) begin
            k++;
            @(negedge clk);
        end
        chk("sim_gnt", 32'(gnt), 32'h2);
        nce = 0;
        k = 0;
        while (k < 60) begin
            if (ce1ms && gnt != 4'b0) nce++;
            if (nce == 3) break;
            k++;
            @(negedge clk);
        end
        req = 4'b0000;
        chk("sim_gnt_before", 32'(gnt), 32'h2);
        @(negedge clk);
        chk("sim_gnt_after", 32'(gnt), 32'h0);
        chk("sim_slot_end", 32'(slot_end), 32'h1);
        bc = 0;
        while (busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        chk_range("sim_busy_fall", bc, 1, 11);

        // Asynchronous reset mid-grant with slot_cnt at 2
        req = 4'b1000;
        k = 0;
        while (gnt == 4'b0 && k < 60) begin
            k++;
            @(negedge clk);
        end
        chk("ar_gnt", 32'(gnt), 32'h8);
        k = 0;
        while (!(ce1ms && gnt != 4'b0) && k < 40) begin
            k++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("ar_gnt_held", 32'(gnt), 32'h8);
        #1 rst = 1'b1;
        #1;
        chk("ar_gnt_cleared", 32'(gnt), 32'h0);
        chk("ar_busy_cleared", 32'(busy), 32'h0);
        chk("ar_gnt_id_cleared", 32'(gnt_id), 32'h0);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_regrant", 32'(gnt), 32'h1);
        chk("ar_regrant_id", 32'(gnt_id), 32'h0);
        req = 4'b0000;

        // GUARD_MS=0: alternating grants with exactly one idle cycle between
        req0 = 4'b0011;
        k = 0;
        while (gnt0 == 4'b0 && k < 60) begin
            k++;
            @(negedge clk);
        end
        exp0 = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("g0_gnt[%0d]", s), 32'(gnt0), 32'(exp0));
            hc = 0;
            while (gnt0 != 4'b0 && hc < 60) begin
                hc++;
                @(negedge clk);
            end
            chk_range($sformatf("g0_slot_len[%0d]", s), hc, 21, 30);
            chk($sformatf("g0_slot_end[%0d]", s), 32'(slot_end0), 32'h1);
            chk($sformatf("g0_busy_gap[%0d]", s), 32'(busy0), 32'h0);
            zc = 0;
            while (gnt0 == 4'b0 && zc < 60) begin
                zc++;
                @(negedge clk);
            end
            chk($sformatf("g0_gap[%0d]", s), 32'(zc), 32'd1);
            exp0 = (exp0 == 4'b0001) ? 4'b0010 : 4'b0001;
        end
        req0 = 4'b0000;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
